// File: rtl/instr_loader.sv
// instr_loader: boot-time program writer for the byte-addressed instruction memory.
// A byte stream (valid/ready) is packed little-endian into 32-bit words and sent to
// the memory's registered word-write port. Words go to consecutive addresses from
// BASE_ADDR. The core is held in reset until done is high.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, one checksum byte
// follows the image. The 8-bit sum of all image bytes plus the checksum must be zero.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     begin a fresh load (sampled in IDLE/DONE/ERR)
//   s_data    stream byte
//   s_valid   s_data valid
//   s_last    final image byte marker (qualified by s_valid)
//   s_ready   loader accepts a byte this cycle
//   we        one-cycle word write strobe
//   WA        word byte address (always 4-byte aligned)
//   WD        packed word, first stream byte in WD[7:0]
//   busy      high while loading (LOAD / CHECK)
//   done      high while in DONE
//   err       high while in ERR (overflow or bad checksum)
//   word_cnt  words written since the last start
module instr_loader #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 8,
  parameter int unsigned                INSTR_WIDTH   = 32,
  parameter int unsigned                MEM_BYTES     = 4096,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] WA,
  output logic [INSTR_WIDTH-1:0]   WD,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDRESS_WIDTH-1:0] word_cnt
);

  // One bit wider than the address so that BASE_ADDR + MEM_BYTES cannot wrap.
  localparam logic [ADDRESS_WIDTH:0]   ADDR_LIMIT =
    {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(MEM_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] MAX_WORDS = ADDRESS_WIDTH'(MEM_BYTES / 4);
  localparam int unsigned              BUF_W     = INSTR_WIDTH - DATA_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERR} state_t;
`endif

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [1:0]               lane_q;
  logic [BUF_W-1:0]         buf_q;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    sum_q;
`endif

  logic                     clear_load;
  logic                     take_byte;
  logic                     write_word;
  logic                     overflow;
  logic [INSTR_WIDTH-1:0]   word_pack;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    clear_load = 1'b0;
    take_byte  = 1'b0;
    write_word = 1'b0;
    overflow   = ({1'b0, wr_addr_q} >= ADDR_LIMIT);
    // Lanes above the current one are already zero in buf_q, so a partial word
    // is padded with 0x00 automatically.
    word_pack  = {{DATA_WIDTH{1'b0}}, buf_q};
    word_pack[{lane_q, 3'b000} +: DATA_WIDTH] = s_data;

    case (state_q)
      IDLE, DONE, ERR: begin
        done = (state_q == DONE);
        err  = (state_q == ERR);
        if (start) begin
          state_d    = LOAD;
          clear_load = 1'b1;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (overflow) begin
            state_d = ERR;
          end else begin
            take_byte  = 1'b1;
            write_word = (lane_q == 2'd3) || s_last;
            if (s_last) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          state_d = (DATA_WIDTH'(sum_q + s_data) == '0) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we        <= 1'b0;
      WA        <= BASE_ADDR;
      WD        <= '0;
      word_cnt  <= '0;
      wr_addr_q <= BASE_ADDR;
      lane_q    <= '0;
      buf_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (clear_load) begin
        word_cnt  <= '0;
        wr_addr_q <= BASE_ADDR;
        lane_q    <= '0;
        buf_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_q     <= '0;
`endif
      end
      if (take_byte) begin
`ifdef LOADER_CHECKSUM_EN
        sum_q <= sum_q + s_data;
`endif
        if (write_word) begin
          we        <= 1'b1;
          WA        <= wr_addr_q;
          WD        <= word_pack;
          wr_addr_q <= wr_addr_q + ADDRESS_WIDTH'(4);
          lane_q    <= '0;
          buf_q     <= '0;
          if (word_cnt != MAX_WORDS) word_cnt <= word_cnt + 1'b1;
        end else begin
          lane_q <= lane_q + 2'd1;
          buf_q  <= word_pack[BUF_W-1:0];
        end
      end
    end
  end

  a_wa_aligned: assert property (@(posedge clk) we |-> (WA[1:0] == 2'b00));
  a_base_aligned: assert property (@(posedge clk) BASE_ADDR[1:0] == 2'b00);
  a_widths: assert property (@(posedge clk) (DATA_WIDTH == 8) && (INSTR_WIDTH == 32));

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader. It drives a main instance
// (4 KiB memory) and a tiny instance (8-byte memory) that exercises overflow.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_start = 1'b0, m_valid = 1'b0, m_last = 1'b0;
  logic [7:0]  m_data = '0;
  logic        m_ready, m_we, m_busy, m_done, m_err;
  logic [31:0] m_wa, m_wd, m_cnt;

  logic        t_start = 1'b0, t_valid = 1'b0, t_last = 1'b0;
  logic [7:0]  t_data = '0;
  logic        t_ready, t_we, t_busy, t_done, t_err;
  logic [31:0] t_wa, t_wd, t_cnt;

  instr_loader #(.ADDRESS_WIDTH(32), .MEM_BYTES(4096), .BASE_ADDR(32'h0)) u_main (
    .clk(clk), .rst_n(rst_n), .start(m_start), .s_data(m_data), .s_valid(m_valid),
    .s_last(m_last), .s_ready(m_ready), .we(m_we), .WA(m_wa), .WD(m_wd),
    .busy(m_busy), .done(m_done), .err(m_err), .word_cnt(m_cnt)
  );

  instr_loader #(.ADDRESS_WIDTH(32), .MEM_BYTES(8), .BASE_ADDR(32'h0)) u_tiny (
    .clk(clk), .rst_n(rst_n), .start(t_start), .s_data(t_data), .s_valid(t_valid),
    .s_last(t_last), .s_ready(t_ready), .we(t_we), .WA(t_wa), .WD(t_wd),
    .busy(t_busy), .done(t_done), .err(t_err), .word_cnt(t_cnt)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  img [$];
  logic [7:0]  img_sum;
  logic [31:0] m_wa_q [$], m_wd_q [$], t_wa_q [$], t_wd_q [$];

  always @(negedge clk) begin
    if (m_we) begin m_wa_q.push_back(m_wa); m_wd_q.push_back(m_wd); end
    if (t_we) begin t_wa_q.push_back(t_wa); t_wd_q.push_back(t_wd); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_load(input bit tiny);
    if (tiny) t_start = 1'b1; else m_start = 1'b1;
    tick(1);
    t_start = 1'b0;
    m_start = 1'b0;
    img_sum = '0;
    if (tiny) begin t_wa_q.delete(); t_wd_q.delete(); end
    else      begin m_wa_q.delete(); m_wd_q.delete(); end
  endtask

  task automatic send_byte(input bit tiny, input logic [7:0] d, input bit last);
    int unsigned n;
    bit rdy;
    if (tiny) begin t_data = d; t_valid = 1'b1; t_last = last; end
    else      begin m_data = d; m_valid = 1'b1; m_last = last; end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = tiny ? t_ready : m_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    else      img_sum = img_sum + d;
    t_valid = 1'b0; t_last = 1'b0;
    m_valid = 1'b0; m_last = 1'b0;
  endtask

  task automatic run_image(input bit tiny, input int unsigned gap);
    for (int i = 0; i < img.size(); i++) begin
      send_byte(tiny, img[i], i == img.size() - 1);
      tick(gap);
    end
  endtask

  // Good checksum for checksum-enabled builds; no-op otherwise.
  task automatic finish_image(input bit tiny);
`ifdef LOADER_CHECKSUM_EN
    send_byte(tiny, 8'h00 - img_sum, 1'b0);
`else
    if (tiny) tick(0);
`endif
  endtask

  task automatic expect_word(input bit tiny, input string tag, input int unsigned i,
                             input logic [31:0] wa, input logic [31:0] wd);
    int unsigned sz;
    sz = tiny ? t_wa_q.size() : m_wa_q.size();
    if (i < sz) begin
      check({tag, "_wa"}, tiny ? t_wa_q[i] : m_wa_q[i], wa);
      check({tag, "_wd"}, tiny ? t_wd_q[i] : m_wd_q[i], wd);
    end else begin
      check({tag, "_missing"}, 32'(sz), 32'(i + 1));
    end
  endtask

  initial begin
    tick(2);
    @(negedge clk);
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_we",    32'(m_we),    32'd0);
    check("rst_done",  32'(m_done),  32'd0);
    check("rst_err",   32'(m_err),   32'd0);
    check("rst_busy",  32'(m_busy),  32'd0);
    check("rst_wa",    m_wa,         32'd0);
    check("rst_cnt",   m_cnt,        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // Two full words, back to back.
    start_load(1'b0);
    @(negedge clk);
    check("load_busy", 32'(m_busy), 32'd1);
    @(posedge clk); #1;
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_image(1'b0, 0);
    finish_image(1'b0);
    tick(3);
    check("b2b_nwords", 32'(m_wa_q.size()), 32'd2);
    expect_word(1'b0, "b2b_w0", 0, 32'h0, 32'h00000013);
    expect_word(1'b0, "b2b_w1", 1, 32'h4, 32'h00100093);
    check("b2b_done",  32'(m_done),  32'd1);
    check("b2b_cnt",   m_cnt,        32'd2);
    check("b2b_ready", 32'(m_ready), 32'd0);
    check("b2b_hold_wd", m_wd,       32'h00100093);

    // Partial final word padded with zeros.
    start_load(1'b0);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_image(1'b0, 0);
    finish_image(1'b0);
    tick(3);
    check("part_nwords", 32'(m_wa_q.size()), 32'd2);
    expect_word(1'b0, "part_w0", 0, 32'h0, 32'hDDCCBBAA);
    expect_word(1'b0, "part_w1", 1, 32'h4, 32'h00002211);
    check("part_done", 32'(m_done), 32'd1);

    // Same image as the first, with an idle cycle between bytes.
    start_load(1'b0);
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_image(1'b0, 1);
    finish_image(1'b0);
    tick(3);
    check("gap_nwords", 32'(m_wa_q.size()), 32'd2);
    expect_word(1'b0, "gap_w0", 0, 32'h0, 32'h00000013);
    expect_word(1'b0, "gap_w1", 1, 32'h4, 32'h00100093);
    check("gap_cnt", m_cnt, 32'd2);

    // Overflow on the 8-byte instance: the 9th byte must raise err and not be written.
    start_load(1'b1);
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_image(1'b1, 0);
    tick(3);
    check("ovf_nwords", 32'(t_wa_q.size()), 32'd2);
    expect_word(1'b1, "ovf_w0", 0, 32'h0, 32'h04030201);
    expect_word(1'b1, "ovf_w1", 1, 32'h4, 32'h08070605);
    check("ovf_err",  32'(t_err),  32'd1);
    check("ovf_done", 32'(t_done), 32'd0);
    check("ovf_cnt",  t_cnt,       32'd2);

    // Reset in the middle of a load discards the partial word.
    start_load(1'b0);
    send_byte(1'b0, 8'h55, 1'b0);
    send_byte(1'b0, 8'h66, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("mrst_nwords", 32'(m_wa_q.size()), 32'd0);
    check("mrst_cnt",    m_cnt,              32'd0);
    check("mrst_busy",   32'(m_busy),        32'd0);
    start_load(1'b0);
    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_image(1'b0, 0);
    finish_image(1'b0);
    tick(3);
    check("reload_nwords", 32'(m_wa_q.size()), 32'd1);
    expect_word(1'b0, "reload_w0", 0, 32'h0, 32'hDEADBEEF);
    check("reload_done", 32'(m_done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 01+02+03+04 = 0x0A, so 0xF6 brings the sum to zero and 0xFC does not.
    start_load(1'b0);
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_image(1'b0, 0);
    send_byte(1'b0, 8'hF6, 1'b0);
    tick(3);
    check("chk_ok_done", 32'(m_done), 32'd1);
    check("chk_ok_nwords", 32'(m_wa_q.size()), 32'd1);
    start_load(1'b0);
    run_image(1'b0, 0);
    send_byte(1'b0, 8'hFC, 1'b0);
    tick(3);
    check("chk_bad_err", 32'(m_err), 32'd1);
    check("chk_bad_nwords", 32'(m_wa_q.size()), 32'd1);
    expect_word(1'b0, "chk_bad_w0", 0, 32'h0, 32'h04030201);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
